// File: rtl/rasterbar_sched.sv
// Rasterbar scheduler: walks a per-frame bar table in index order and hands each
// enabled bar to one shared renderer when its start line comes round.
module rasterbar_sched #(
  parameter int BARS  = 8,
  parameter int CORDW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame,
  input  logic                     line,
  input  logic [CORDW-1:0]         sy,
  input  logic                     cfg_we,
  input  logic [$clog2(BARS)-1:0]  cfg_addr,
  input  logic                     cfg_en,
  input  logic [CORDW-1:0]         cfg_y,
  input  logic [11:0]              cfg_colr,
  input  logic                     bar_done,
  output logic                     bar_start,
  output logic [11:0]              bar_base_colr,
  output logic [$clog2(BARS)-1:0]  active_idx,
  output logic                     busy,
  output logic [7:0]               missed,
  output logic                     frame_done
);

  localparam int IW = $clog2(BARS);

  // state     | meaning
  // IDLE      | waiting for frame
  // SEEK      | stepping idx to the next enabled entry, or ending the walk
  // WAIT_LINE | entry latched, waiting for its start line
  // RUN       | renderer started, waiting for bar_done
  typedef enum logic [1:0] {IDLE, SEEK, WAIT_LINE, RUN} state_t;

  state_t r_state, w_state_nxt;

  logic             r_en   [BARS];
  logic [CORDW-1:0] r_y    [BARS];
  logic [11:0]      r_colr [BARS];

  // one extra bit so idx==BARS is reachable without wrapping
  logic [IW:0]      r_idx;
  logic [CORDW-1:0] r_y_lat;
  logic [11:0]      r_colr_lat;
  logic [IW-1:0]    r_active_idx;
  logic [7:0]       r_missed;
  logic             r_start;

  logic w_idx_end, w_entry_en, w_line_hit, w_line_past;

  assign w_idx_end   = (r_idx == (IW+1)'(BARS));
  assign w_entry_en  = r_en[r_idx[IW-1:0]];
  assign w_line_hit  = line && (sy == r_y_lat);
  assign w_line_past = line && (sy > r_y_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BARS; i++) begin
        r_en[i]   <= 1'b0;
        r_y[i]    <= '0;
        r_colr[i] <= '0;
      end
    end else if (cfg_we) begin
      r_en[cfg_addr]   <= cfg_en;
      r_y[cfg_addr]    <= cfg_y;
      r_colr[cfg_addr] <= cfg_colr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      w_state_nxt = IDLE;
      SEEK: begin
        if (w_idx_end)       w_state_nxt = IDLE;
        else if (w_entry_en) w_state_nxt = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (w_line_hit)       w_state_nxt = RUN;
        else if (w_line_past) w_state_nxt = SEEK;
      end
      RUN:       if (bar_done) w_state_nxt = SEEK;
      default:   w_state_nxt = IDLE;
    endcase
    if (frame) w_state_nxt = SEEK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_y_lat      <= '0;
      r_colr_lat   <= '0;
      r_active_idx <= '0;
      r_missed     <= '0;
      r_start      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (frame) begin
        r_idx    <= '0;
        r_missed <= '0;
      end else begin
        case (r_state)
          SEEK: begin
            if (!w_idx_end) begin
              if (w_entry_en) begin
                r_y_lat      <= r_y[r_idx[IW-1:0]];
                r_colr_lat   <= r_colr[r_idx[IW-1:0]];
                r_active_idx <= r_idx[IW-1:0];
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
          end
          WAIT_LINE: begin
            if (w_line_hit) begin
              r_start <= 1'b1;
            end else if (w_line_past) begin
              if (r_missed != 8'hFF) r_missed <= r_missed + 8'd1;
              r_idx <= r_idx + 1'b1;
            end
          end
          RUN:     if (bar_done) r_idx <= r_idx + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bar_start     = r_start;
  assign bar_base_colr = r_colr_lat;
  assign active_idx    = r_active_idx;
  assign busy          = (r_state == WAIT_LINE) || (r_state == RUN);
  assign missed        = r_missed;
  assign frame_done    = (r_state == SEEK) && w_idx_end;

endmodule

// File: tb/tb_rasterbar_sched.sv
// Directed bench for rasterbar_sched: one table-driven frame walk plus
// hand-written sequences for frame timing, misses, frame pre-emption and reset.
module tb_rasterbar_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame, line, cfg_we, cfg_en, bar_done;
  logic [15:0] sy, cfg_y;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_colr;
  logic        bar_start, busy, frame_done;
  logic [11:0] bar_base_colr;
  logic [2:0]  active_idx;
  logic [7:0]  missed;

  int n_pass = 0;
  int n_tot  = 0;
  int n_start = 0;

  always #5 clk = ~clk;

  rasterbar_sched #(.BARS(8), .CORDW(16)) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .line(line), .sy(sy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_en(cfg_en), .cfg_y(cfg_y),
    .cfg_colr(cfg_colr), .bar_done(bar_done), .bar_start(bar_start),
    .bar_base_colr(bar_base_colr), .active_idx(active_idx), .busy(busy),
    .missed(missed), .frame_done(frame_done)
  );

  typedef struct {
    logic fr, ln, bd;
    int   sy;
    logic e_start, e_busy, e_fdone;
    int   e_idx, e_missed, e_colr;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic fr, ln, bd, input int s,
                              input logic es, eb, ef, input int ei, em, ec);
    vec_t v;
    v.fr = fr; v.ln = ln; v.bd = bd; v.sy = s;
    v.e_start = es; v.e_busy = eb; v.e_fdone = ef;
    v.e_idx = ei; v.e_missed = em; v.e_colr = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick(input logic fr, input logic ln, input int s, input logic bd);
    frame = fr; line = ln; sy = 16'(s); bar_done = bd;
    @(posedge clk); #1;
    frame = 0; line = 0; bar_done = 0; cfg_we = 0;
    if (bar_start) n_start++;
  endtask

  task automatic cfg_write(input int a, input logic en, input int y, input int c);
    cfg_we = 1; cfg_addr = 3'(a); cfg_en = en; cfg_y = 16'(y); cfg_colr = 12'(c);
    tick(0, 0, 0, 0);
  endtask

  task automatic lines(input int from, input int to);
    for (int s = from; s <= to; s++) tick(0, 1, s, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // frame on the first tick; frame_done must appear once, exp_cyc ticks in
  task automatic frame_walk(input string nm, input int exp_cyc);
    int first = 0;
    int cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(i == 1, 0, 0, 0);
      if (frame_done) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk({nm, "_fdone_cycle"}, first, exp_cyc);
    chk({nm, "_fdone_count"}, cnt, 1);
  endtask

  task automatic wait_fdone(input string nm);
    int seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick(0, 0, 0, 0);
      if (frame_done) seen = 1;
    end
    chk({nm, "_fdone_seen"}, seen, 1);
  endtask

  initial begin
    frame = 0; line = 0; sy = 0; bar_done = 0;
    cfg_we = 0; cfg_addr = 0; cfg_en = 0; cfg_y = 0; cfg_colr = 0;
    rst_n = 0;
    #12;
    chk("rst_bar_start", int'(bar_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_missed", int'(missed), 0);
    chk("rst_colr", int'(bar_base_colr), 0);
    chk("rst_active_idx", int'(active_idx), 0);
    rst_n = 1;
    @(posedge clk); #1;

    // all entries disabled
    n_start = 0;
    frame_walk("empty", 9);
    chk("empty_starts", n_start, 0);
    chk("empty_missed", int'(missed), 0);

    // entries 0 and 3, bar_done for entry0 arrives with line 20
    cfg_write(0, 1, 10, 'h111);
    cfg_write(3, 1, 40, 'h333);
    tbl[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0, 0, 'h000);
    tbl[1]  = mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 'h111);
    tbl[2]  = mk(0, 1, 0,  9, 0, 1, 0, 0, 0, 'h111);
    tbl[3]  = mk(0, 1, 0, 10, 1, 1, 0, 0, 0, 'h111);
    tbl[4]  = mk(0, 0, 0,  0, 0, 1, 0, 0, 0, 'h111);
    tbl[5]  = mk(0, 1, 1, 20, 0, 0, 0, 0, 0, 'h111);
    tbl[6]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 'h111);
    tbl[7]  = mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 'h111);
    tbl[8]  = mk(0, 0, 0,  0, 0, 1, 0, 3, 0, 'h333);
    tbl[9]  = mk(0, 1, 0, 39, 0, 1, 0, 3, 0, 'h333);
    tbl[10] = mk(0, 1, 0, 40, 1, 1, 0, 3, 0, 'h333);
    tbl[11] = mk(0, 0, 0,  0, 0, 1, 0, 3, 0, 'h333);
    tbl[12] = mk(0, 0, 1,  0, 0, 0, 0, 3, 0, 'h333);
    tbl[13] = mk(0, 0, 0,  0, 0, 0, 0, 3, 0, 'h333);
    tbl[14] = mk(0, 0, 0,  0, 0, 0, 0, 3, 0, 'h333);
    tbl[15] = mk(0, 0, 0,  0, 0, 0, 0, 3, 0, 'h333);
    tbl[16] = mk(0, 0, 0,  0, 0, 0, 1, 3, 0, 'h333);
    tbl[17] = mk(0, 0, 0,  0, 0, 0, 0, 3, 0, 'h333);
    for (int r = 0; r < 18; r++) begin
      tick(tbl[r].fr, tbl[r].ln, tbl[r].sy, tbl[r].bd);
      chk($sformatf("v%0d_start", r), int'(bar_start), int'(tbl[r].e_start));
      chk($sformatf("v%0d_busy", r), int'(busy), int'(tbl[r].e_busy));
      chk($sformatf("v%0d_fdone", r), int'(frame_done), int'(tbl[r].e_fdone));
      chk($sformatf("v%0d_idx", r), int'(active_idx), tbl[r].e_idx);
      chk($sformatf("v%0d_missed", r), int'(missed), tbl[r].e_missed);
      chk($sformatf("v%0d_colr", r), int'(bar_base_colr), tbl[r].e_colr);
    end

    // entry0 at line 100
    do_reset();
    cfg_write(0, 1, 100, 'h126);
    n_start = 0;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    lines(0, 99);
    chk("y100_early_start", n_start, 0);
    tick(0, 1, 100, 0);
    chk("y100_start", int'(bar_start), 1);
    chk("y100_colr", int'(bar_base_colr), 'h126);
    chk("y100_idx", int'(active_idx), 0);
    chk("y100_busy", int'(busy), 1);
    tick(0, 0, 0, 0);
    chk("y100_start_drop", int'(bar_start), 0);
    chk("y100_start_count", n_start, 1);
    tick(0, 0, 0, 1);
    wait_fdone("y100");

    // entry1 passes while entry0 is still rendering
    do_reset();
    cfg_write(0, 1, 50, 'h050);
    cfg_write(1, 1, 55, 'h055);
    n_start = 0;
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    lines(0, 59);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    chk("miss_latched_idx", int'(active_idx), 1);
    chk("miss_before", int'(missed), 0);
    tick(0, 1, 60, 0);
    chk("miss_count", int'(missed), 1);
    chk("miss_busy", int'(busy), 0);
    wait_fdone("miss");
    chk("miss_starts", n_start, 1);
    chk("miss_hold", int'(missed), 1);

    // frame together with bar_done and line during RUN of entry1
    cfg_write(0, 1, 5, 'h00A);
    cfg_write(1, 1, 8, 'h00B);
    n_start = 0;
    tick(1, 0, 0, 0);
    chk("pre_missed_clr", int'(missed), 0);
    tick(0, 0, 0, 0);
    lines(0, 5);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    lines(6, 7);
    tick(0, 1, 8, 0);
    chk("pre_run_idx", int'(active_idx), 1);
    chk("pre_run_start", int'(bar_start), 1);
    tick(1, 1, 9, 1);
    chk("pre_busy", int'(busy), 0);
    chk("pre_missed", int'(missed), 0);
    chk("pre_no_start", int'(bar_start), 0);
    tick(0, 0, 0, 0);
    chk("pre_relatch_idx", int'(active_idx), 0);
    chk("pre_relatch_colr", int'(bar_base_colr), 'h00A);
    lines(0, 5);
    chk("pre_starts", n_start, 3);

    // config write during RUN only takes effect next frame, then reset mid-RUN
    cfg_write(0, 1, 5, 'h5A5);
    cfg_write(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    lines(0, 5);
    cfg_write(0, 1, 5, 'hFFF);
    tick(0, 0, 0, 0);
    chk("cfg_old_colr", int'(bar_base_colr), 'h5A5);
    tick(0, 0, 0, 1);
    wait_fdone("cfg");
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("cfg_new_colr", int'(bar_base_colr), 'hFFF);
    lines(0, 5);
    chk("cfg_run_busy", int'(busy), 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_colr", int'(bar_base_colr), 0);
    chk("arst_start", int'(bar_start), 0);
    chk("arst_fdone", int'(frame_done), 0);
    #3;
    rst_n = 1;
    @(posedge clk); #1;
    n_start = 0;
    frame_walk("cleared", 9);
    chk("cleared_starts", n_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
